// File: rtl/switch_allocator_pkg.sv
// Shared router configuration: port count, crossbar idle select and port-index encoding.
// The crossbar imports the same package so select values always agree.
package switch_allocator_pkg;

    localparam int unsigned NUM_PORTS = 5;
    localparam int unsigned SEL_W     = 3;
    localparam logic [SEL_W-1:0] SEL_IDLE = 3'b101;

    typedef enum logic [SEL_W-1:0] {
        LOCAL = 3'd0,
        NORTH = 3'd1,
        EAST  = 3'd2,
        SOUTH = 3'd3,
        WEST  = 3'd4
    } port_e;

endpackage

// File: rtl/switch_allocator_rr_arbiter.sv
// Round-robin arbiter for one output port: searches upward from its own pointer and
// advances the pointer past the winner only when a grant is issued.
module rr_arbiter
    import switch_allocator_pkg::*;
#(
    parameter int unsigned N = NUM_PORTS
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [N-1:0]     req,
    input  logic             en,
    output logic [N-1:0]     gnt,
    output logic [SEL_W-1:0] idx,
    output logic             valid
);

    logic [SEL_W-1:0] ptr_q, ptr_d;
    logic [SEL_W:0]   cand;
    logic             found;

    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        cand  = '0;
        for (int k = 0; k < N; k++) begin
            cand = {1'b0, ptr_q} + (SEL_W + 1)'(k);
            if (cand >= (SEL_W + 1)'(N)) begin
                cand = cand - (SEL_W + 1)'(N);
            end
            if (!found && req[cand[SEL_W-1:0]]) begin
                found = 1'b1;
                idx   = cand[SEL_W-1:0];
            end
        end
        valid = en & found;
        if (valid) begin
            gnt[idx] = 1'b1;
        end
        ptr_d = ptr_q;
        if (valid) begin
            ptr_d = (idx == SEL_W'(N - 1)) ? '0 : idx + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/switch_allocator.sv
// Router switch allocator: one round-robin arbiter per output, results registered so that
// sel/grant/out_valid appear one cycle after the sampled requests.
module switch_allocator
    import switch_allocator_pkg::*;
#(
    parameter int unsigned PORT_NUM = NUM_PORTS
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [PORT_NUM-1:0]       req,
    input  logic [SEL_W*PORT_NUM-1:0] dest,
    input  logic [PORT_NUM-1:0]       out_ready,
    output logic [SEL_W*PORT_NUM-1:0] sel,
    output logic [PORT_NUM-1:0]       grant,
    output logic [PORT_NUM-1:0]       out_valid,
    output logic                      err_dest
);

    localparam logic [SEL_W-1:0] MAX_IDX = SEL_W'(PORT_NUM - 1);

    logic [PORT_NUM-1:0]                legal;
    logic [PORT_NUM-1:0]                eligible;
    logic [PORT_NUM-1:0][PORT_NUM-1:0]  arb_req;
    logic [PORT_NUM-1:0][PORT_NUM-1:0]  arb_gnt;
    logic [PORT_NUM-1:0][SEL_W-1:0]     arb_idx;
    logic [PORT_NUM-1:0]                arb_valid;
    logic [SEL_W*PORT_NUM-1:0]          sel_d;
    logic [PORT_NUM-1:0]                grant_d;
    logic                               err_d;

    // An input that is popping this cycle is masked so one packet is never granted twice.
    always_comb begin
        legal    = '0;
        eligible = '0;
        arb_req  = '0;
        for (int i = 0; i < PORT_NUM; i++) begin
            legal[i]    = dest[SEL_W*i +: SEL_W] <= MAX_IDX;
            eligible[i] = req[i] & legal[i] & ~grant[i];
        end
        for (int o = 0; o < PORT_NUM; o++) begin
            for (int i = 0; i < PORT_NUM; i++) begin
                arb_req[o][i] = eligible[i] && (dest[SEL_W*i +: SEL_W] == SEL_W'(o));
            end
        end
    end

    for (genvar g = 0; g < PORT_NUM; g++) begin : g_arb
        rr_arbiter #(
            .N(PORT_NUM)
        ) u_arb (
            .clk    (clk),
            .reset_n(reset_n),
            .req    (arb_req[g]),
            .en     (out_ready[g]),
            .gnt    (arb_gnt[g]),
            .idx    (arb_idx[g]),
            .valid  (arb_valid[g])
        );
    end

    always_comb begin
        grant_d = '0;
        sel_d   = '0;
        err_d   = err_dest;
        for (int o = 0; o < PORT_NUM; o++) begin
            grant_d                 = grant_d | arb_gnt[o];
            sel_d[SEL_W*o +: SEL_W] = arb_valid[o] ? arb_idx[o] : SEL_IDLE;
        end
        for (int i = 0; i < PORT_NUM; i++) begin
            if (req[i] && !legal[i]) begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sel       <= {PORT_NUM{SEL_IDLE}};
            grant     <= '0;
            out_valid <= '0;
            err_dest  <= 1'b0;
        end else begin
            sel       <= sel_d;
            grant     <= grant_d;
            out_valid <= arb_valid;
            err_dest  <= err_d;
        end
    end

endmodule

// File: tb/tb_switch_allocator.sv
// Bench for switch_allocator: directed scenarios plus random traffic, checked through a
// scoreboard fed by a per-cycle reference model of the allocation rules.
module tb_switch_allocator;

    localparam int P = 5;

    logic           clk = 1'b0;
    logic           reset_n = 1'b0;
    logic [P-1:0]   req = '0;
    logic [3*P-1:0] dest = '0;
    logic [P-1:0]   out_ready = '0;
    logic [3*P-1:0] sel;
    logic [P-1:0]   grant;
    logic [P-1:0]   out_valid;
    logic           err_dest;

    switch_allocator #(
        .PORT_NUM(P)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .req      (req),
        .dest     (dest),
        .out_ready(out_ready),
        .sel      (sel),
        .grant    (grant),
        .out_valid(out_valid),
        .err_dest (err_dest)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3*P-1:0] sel;
        logic [P-1:0]   grant;
        logic [P-1:0]   ov;
        logic           err;
    } exp_t;

    exp_t exp_q[$];
    int   m_ptr[P];
    bit   m_prev[P];
    bit   m_err;
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req_v);
        checks++;
        if (act !== req_v) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, req_v);
        end
    endtask

    // Apply one cycle of inputs and predict the registered response for the next cycle.
    task automatic step(input logic rn, input logic [P-1:0] r, input logic [3*P-1:0] d,
                        input logic [P-1:0] rdy);
        exp_t e;
        bit   found;
        int   i;
        @(negedge clk);
        reset_n   = rn;
        req       = r;
        dest      = d;
        out_ready = rdy;
        e.sel   = {P{3'd5}};
        e.grant = '0;
        e.ov    = '0;
        e.err   = 1'b0;
        if (!rn) begin
            for (int k = 0; k < P; k++) begin
                m_ptr[k]  = 0;
                m_prev[k] = 0;
            end
            m_err = 0;
        end else begin
            for (int k = 0; k < P; k++) begin
                if (r[k] && int'(d[3*k +: 3]) > P - 1) m_err = 1;
            end
            for (int o = 0; o < P; o++) begin
                found = 0;
                if (rdy[o]) begin
                    for (int k = 0; k < P; k++) begin
                        i = (m_ptr[o] + k) % P;
                        if (!found && r[i] && !m_prev[i] && int'(d[3*i +: 3]) == o) begin
                            found          = 1;
                            e.grant[i]     = 1'b1;
                            e.ov[o]        = 1'b1;
                            e.sel[3*o +: 3] = 3'(i);
                            m_ptr[o]       = (i + 1) % P;
                        end
                    end
                end
            end
            for (int k = 0; k < P; k++) m_prev[k] = e.grant[k];
            e.err = m_err;
        end
        exp_q.push_back(e);
    endtask

    function automatic logic [3*P-1:0] all_dest(input int v);
        logic [3*P-1:0] d;
        for (int k = 0; k < P; k++) d[3*k +: 3] = 3'(v);
        return d;
    endfunction

    // Monitor: outputs are presented every cycle; compare just after each rising edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("sel", 32'(sel), 32'(e.sel));
                check("grant", 32'(grant), 32'(e.grant));
                check("out_valid", 32'(out_valid), 32'(e.ov));
                check("err_dest", 32'(err_dest), 32'(e.err));
            end
        end
    end

    initial begin
        logic [3*P-1:0] d;
        logic           rn;
        step(1'b0, '0, '0, '0);
        step(1'b0, '0, '0, '0);
        repeat (3) step(1'b1, '0, '0, '1);
        // Single request held: grant, masked cycle, grant again.
        repeat (4) step(1'b1, 5'b00100, all_dest(4), '1);
        step(1'b1, '0, '0, '1);
        // Contention on output 2 from inputs 0,1,3.
        repeat (10) step(1'b1, 5'b01011, all_dest(2), '1);
        // Backpressure on output 1, then release.
        repeat (4) step(1'b1, 5'b00001, all_dest(1), 5'b11101);
        repeat (3) step(1'b1, 5'b00001, all_dest(1), '1);
        // Parallel grants: input i targets (i+1)%P.
        for (int k = 0; k < P; k++) d[3*k +: 3] = 3'((k + 1) % P);
        repeat (2) step(1'b1, '1, d, '1);
        // Illegal destination; error flag must stick.
        d = all_dest(0);
        d[9 +: 3] = 3'd6;
        step(1'b1, 5'b01000, d, '1);
        repeat (3) step(1'b1, '0, '0, '1);
        // Mid-run reset during contention.
        repeat (3) step(1'b1, 5'b01011, all_dest(2), '1);
        step(1'b0, 5'b01011, all_dest(2), '1);
        repeat (4) step(1'b1, 5'b01011, all_dest(2), '1);
        // Random traffic.
        for (int n = 0; n < 400; n++) begin
            for (int k = 0; k < P; k++) begin
                d[3*k +: 3] = ($urandom_range(0, 19) == 0) ? 3'($urandom_range(5, 7))
                                                            : 3'($urandom_range(0, 4));
            end
            rn = ($urandom_range(0, 99) >= 3);
            step(rn, 5'($urandom), d, 5'($urandom | $urandom));
        end
        repeat (2) step(1'b1, '0, '0, '1);
        repeat (3) @(posedge clk);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/switch_allocator.md
SWITCH_ALLOCATOR -- requirements
Module: switch_allocator

Interface
REQ-001 SHALL have parameter PORT_NUM, default 5: number of router input ports and output ports.
REQ-002 SHALL have port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset_n, input, 1: reset, synchronous and active-low.
REQ-004 SHALL have port req, input, [0:PORT_NUM-1] x 1: input port i has a head-of-FIFO packet waiting.
REQ-005 SHALL have port dest, input, [0:PORT_NUM-1] x 3: output port requested by input i; valid only while req[i]=1.
REQ-006 SHALL have port out_ready, input, [0:PORT_NUM-1] x 1: downstream of output o can accept one packet this cycle.
REQ-007 SHALL have port sel, output, [0:PORT_NUM-1] x 3: crossbar select per output; value = granted input index, or SEL_IDLE (3'b101) when unconnected.
REQ-008 SHALL have port grant, output, [0:PORT_NUM-1] x 1: one-cycle pulse telling input i to pop its FIFO head.
REQ-009 SHALL have port out_valid, output, [0:PORT_NUM-1] x 1: output o carries a valid packet this cycle.
REQ-010 SHALL have port err_dest, output, 1: sticky flag set when any req[i]=1 carries dest > PORT_NUM-1.

Function
REQ-011 SHALL arbitrate every cycle N on the sampled req, dest and out_ready, and register the results so that sel, grant and out_valid reflect them in cycle N+1 (latency 1).
REQ-012 SHALL treat input i as eligible in cycle N only if req[i]=1, dest[i] <= PORT_NUM-1, and grant[i]=0 in cycle N; the last condition masks an input while it pops, so it is never granted twice for one packet.
REQ-013 SHALL grant output o only when out_ready[o]=1 in cycle N; otherwise sel[o]=SEL_IDLE and out_valid[o]=0 in N+1.
REQ-014 SHALL resolve each output with an independent round-robin arbiter among eligible inputs whose dest equals o; the search starts at pointer ptr[o] and ascends modulo PORT_NUM.
REQ-015 SHALL update ptr[o] to (winner+1) mod PORT_NUM on a grant, wrapping 4->0 for PORT_NUM=5, and SHALL leave ptr[o] unchanged when output o is not granted.
REQ-016 SHALL drive, in cycle N+1 for a winning pair (i,o): grant[i]=1, sel[o]=i, out_valid[o]=1; all other grant bits 0.
REQ-017 SHALL never grant one input to more than one output, and SHALL never connect one output to more than one input, in any cycle.
REQ-018 SHALL allow an input to request its own port index (loopback); it is arbitrated like any other request.
REQ-019 SHALL ignore requests with illegal dest for arbitration and SHALL set err_dest in the following cycle; err_dest clears only on reset.
REQ-020 SHALL give each input at most one grant every 2 cycles; this throughput limit is a consequence of REQ-012.

Reset
REQ-021 SHALL, while reset_n=0 at a clock edge, set all sel to SEL_IDLE, all grant and out_valid to 0, err_dest to 0, and every ptr[o] to 0.
REQ-022 SHALL discard any arbitration result computed in a cycle where reset_n=0 (reset mid-operation); no grant pulse appears in the cycle after reset deasserts.
REQ-023 SHALL resume arbitration on the first edge with reset_n=1; the first possible grant is visible one cycle later.

Structure
REQ-024 SHALL take PORT_NUM, SEL_IDLE=3'b101 and the port-index enumeration (LOCAL=0, NORTH=1, EAST=2, SOUTH=3, WEST=4) from the shared config package, so that the crossbar uses the same encoding.
REQ-025 SHALL instantiate one sub-module rr_arbiter per output: inputs are a PORT_NUM-bit request vector and an enable; it holds its own pointer and returns a one-hot grant plus an index.
REQ-026 SHALL keep all outputs (sel, grant, out_valid, err_dest) registered, with no combinational path from inputs to outputs.

Verification
REQ-027 SHALL verify single request: req[2]=1, dest[2]=4, out_ready[4]=1 at cycle 5 -> cycle 6: grant[2]=1, sel[4]=2, out_valid[4]=1; cycle 7: grant[2]=0 even if req[2] stays 1.
REQ-028 SHALL verify contention and fairness: inputs 0,1,3 held at dest=2 with out_ready[2]=1 -> sel[2] sequence 0,1,3,0,... with ptr wrapping past 4.
REQ-029 SHALL verify backpressure: out_ready[1]=0 for 4 cycles with req[0]=1, dest[0]=1 -> no grant and sel[1]=5 for that period; grant[0] appears 1 cycle after out_ready[1] rises.
REQ-030 SHALL verify parallel grants: all 5 inputs target distinct outputs (i->(i+1)%5) -> all 5 grants in the same cycle, sel={4,0,1,2,3}.
REQ-031 SHALL verify an illegal dest: req[3]=1, dest[3]=6 -> no grant[3], err_dest=1 next cycle and held until reset.
REQ-032 SHALL verify mid-run reset: reset_n=0 for 1 cycle while contention is active -> all sel=5, grant=0, ptr=0; after release, input 0 wins first.
